// File: rtl/reg_i8_stim_check.sv
// Vector-table stimulus/checker: replays up to 16 stored {a, en} steps into a DUT
// and compares the DUT's y against the stored expectation, stopping at the first miss.
module reg_i8_stim_check #(
    parameter logic [7:0] PRE_A  = 8'd9,
    parameter logic       PRE_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_a,
    input  logic       wr_en,
    input  logic [7:0] wr_exp,
    input  logic       start,
    input  logic [4:0] num_steps,
    input  logic [7:0] y,
    output logic [7:0] a,
    output logic       en,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_step,
    output logic [7:0] fail_y
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [4:0] steps_q, steps_d;
    logic [7:0] a_q, a_d;
    logic       en_q, en_d;
    logic       pass_q, pass_d;
    logic [3:0] fail_step_q, fail_step_d;
    logic [7:0] fail_y_q, fail_y_d;

    // Table is deliberately outside the reset domain so vectors survive a reset.
    logic [7:0] tab_a_q   [16];
    logic       tab_en_q  [16];
    logic [7:0] tab_exp_q [16];

    logic       wr_ok;
    logic [4:0] steps_in;
    logic       last_step;

    assign wr_ok     = wr_valid && (state_q != S_RUN);
    assign steps_in  = (num_steps > 5'd16) ? 5'd16 : num_steps;
    assign last_step = ({1'b0, idx_q} == (steps_q - 5'd1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        steps_d     = steps_q;
        a_d         = a_q;
        en_d        = en_q;
        pass_d      = pass_q;
        fail_step_d = fail_step_q;
        fail_y_d    = fail_y_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                a_d  = PRE_A;
                en_d = PRE_EN;
                if (start) begin
                    steps_d = steps_in;
                    idx_d   = 4'd0;
                    pass_d  = 1'b0;
                    if (steps_in == 5'd0) begin
                        state_d = S_DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (y != tab_exp_q[idx_q]) begin
                    state_d     = S_DONE;
                    pass_d      = 1'b0;
                    fail_step_d = idx_q;
                    fail_y_d    = y;
                    a_d         = PRE_A;
                    en_d        = PRE_EN;
                end else if (last_step) begin
                    state_d = S_DONE;
                    pass_d  = 1'b1;
                    a_d     = PRE_A;
                    en_d    = PRE_EN;
                end else begin
                    idx_d = idx_q + 4'd1;
                    a_d   = tab_a_q[idx_q];
                    en_d  = tab_en_q[idx_q];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            steps_q     <= 5'd0;
            a_q         <= PRE_A;
            en_q        <= PRE_EN;
            pass_q      <= 1'b0;
            fail_step_q <= 4'd0;
            fail_y_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            steps_q     <= steps_d;
            a_q         <= a_d;
            en_q        <= en_d;
            pass_q      <= pass_d;
            fail_step_q <= fail_step_d;
            fail_y_q    <= fail_y_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && wr_ok) begin
            tab_a_q[wr_addr]   <= wr_a;
            tab_en_q[wr_addr]  <= wr_en;
            tab_exp_q[wr_addr] <= wr_exp;
        end
    end

    assign a         = a_q;
    assign en        = en_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign fail_step = fail_step_q;
    assign fail_y    = fail_y_q;

endmodule
